// File: rtl/dec_bit_collect.sv
// Gathers 16-bit hard-decision chunks from the node units into a full decoded
// frame, flags duplicate chunk writes, and hands the frame off under valid/ready.
module dec_bit_collect #(
  parameter int CODE_LEN  = 256,
  parameter int CHUNK_W   = 16,
  parameter int CHUNK_NUM = CODE_LEN / CHUNK_W,
  parameter int ADDR_W    = $clog2(CHUNK_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [CHUNK_W-1:0]  bit_in,
  input  logic [ADDR_W-1:0]   bit_addr,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic [CODE_LEN-1:0] frame_out,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                err_dup,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t               state, state_nxt;
  logic [CHUNK_NUM-1:0] mask, mask_nxt;
  logic [CODE_LEN-1:0]  frame_nxt;
  logic                 dup_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask        <= '0;
      frame_out   <= '0;
      err_dup     <= 1'b0;
      bit_ready   <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      frame_out   <= frame_nxt;
      err_dup     <= dup_nxt;
      // Status flags are decoded from the next state so every output is a flop.
      bit_ready   <= (state_nxt == COLLECT);
      frame_valid <= (state_nxt == HOLD);
      busy        <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    frame_nxt = frame_out;
    dup_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          mask_nxt  = '0;
          frame_nxt = '0;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // A new frame_start aborts the partial frame and drops any concurrent chunk.
        if (frame_start) begin
          mask_nxt  = '0;
          frame_nxt = '0;
        end else if (bit_valid) begin
          dup_nxt            = mask[bit_addr];
          mask_nxt[bit_addr] = 1'b1;
          for (int unsigned i = 0; i < CHUNK_NUM; i++) begin
            if (bit_addr == ADDR_W'(i)) begin
              frame_nxt[CODE_LEN-1-i*CHUNK_W -: CHUNK_W] = bit_in;
            end
          end
          if (&mask_nxt) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dec_bit_collect.sv
// Directed-sequence bench for dec_bit_collect with randomized chunk data and
// address orders, checked cycle by cycle against a chunk-array reference model.
module tb_dec_bit_collect;

  localparam int CODE_LEN  = 256;
  localparam int CHUNK_W   = 16;
  localparam int CHUNK_NUM = 16;
  localparam int ADDR_W    = 4;

  logic                clk;
  logic                rst_n;
  logic                frame_start;
  logic [CHUNK_W-1:0]  bit_in;
  logic [ADDR_W-1:0]   bit_addr;
  logic                bit_valid;
  logic                bit_ready;
  logic [CODE_LEN-1:0] frame_out;
  logic                frame_valid;
  logic                frame_ready;
  logic                err_dup;
  logic                busy;

  dec_bit_collect #(
    .CODE_LEN (CODE_LEN),
    .CHUNK_W  (CHUNK_W),
    .CHUNK_NUM(CHUNK_NUM),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .bit_in     (bit_in),
    .bit_addr   (bit_addr),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_dup    (err_dup),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: received chunks per slot, which slots are filled,
  // whether a frame is being gathered, and whether a frame is on offer.
  logic [CHUNK_W-1:0] m_chunk [CHUNK_NUM];
  bit                 m_have  [CHUNK_NUM];
  bit                 m_gathering;
  bit                 m_offered;
  bit                 m_dup;

  int n_assert;
  int n_fail;
  int dup_cnt;
  int perm [CHUNK_NUM];
  logic [CODE_LEN-1:0] snap;

  function automatic logic [CODE_LEN-1:0] model_frame();
    logic [CODE_LEN-1:0] f;
    f = '0;
    for (int i = 0; i < CHUNK_NUM; i++) begin
      f = (f << CHUNK_W) | CODE_LEN'(m_chunk[i]);
    end
    return f;
  endfunction

  function automatic int filled_count();
    int c;
    c = 0;
    for (int i = 0; i < CHUNK_NUM; i++) c += int'(m_have[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CHUNK_NUM; i++) begin
      m_chunk[i] = '0;
      m_have[i]  = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [CODE_LEN-1:0] obs, input logic [CODE_LEN-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare every output shortly after the edge.
  task automatic tick();
    int a;
    @(posedge clk);
    a = int'(bit_addr);
    m_dup = 1'b0;
    if (!rst_n) begin
      model_clear();
      m_gathering = 1'b0;
      m_offered   = 1'b0;
    end else if (m_offered) begin
      if (frame_ready) m_offered = 1'b0;
    end else if (m_gathering) begin
      if (frame_start) begin
        model_clear();
      end else if (bit_valid) begin
        m_dup      = m_have[a];
        m_chunk[a] = bit_in;
        m_have[a]  = 1'b1;
        if (filled_count() == CHUNK_NUM) begin
          m_gathering = 1'b0;
          m_offered   = 1'b1;
        end
      end
    end else if (frame_start) begin
      model_clear();
      m_gathering = 1'b1;
    end
    #1;
    chk("frame_valid", CODE_LEN'(frame_valid), CODE_LEN'(m_offered));
    chk("bit_ready",   CODE_LEN'(bit_ready),   CODE_LEN'(m_gathering));
    chk("busy",        CODE_LEN'(busy),        CODE_LEN'(m_gathering | m_offered));
    chk("err_dup",     CODE_LEN'(err_dup),     CODE_LEN'(m_dup));
    chk("frame_out",   frame_out,              model_frame());
    if (err_dup === 1'b1) dup_cnt++;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic write_one(input int a, input logic [CHUNK_W-1:0] d);
    if ($urandom_range(0, 3) == 0) tick();
    bit_valid = 1'b1;
    bit_addr  = ADDR_W'(a);
    bit_in    = d;
    tick();
    bit_valid = 1'b0;
    bit_in    = CHUNK_W'($urandom);
  endtask

  task automatic shuffle();
    int j, t;
    for (int i = 0; i < CHUNK_NUM; i++) perm[i] = i;
    for (int i = CHUNK_NUM - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic move_front(input int pos, input int val);
    int t;
    for (int i = 0; i < CHUNK_NUM; i++) begin
      if (perm[i] == val) begin
        t = perm[pos]; perm[pos] = perm[i]; perm[i] = t;
      end
    end
  endtask

  task automatic write_perm(input int from, input int to);
    for (int i = from; i <= to; i++) write_one(perm[i], CHUNK_W'($urandom));
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tick();
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    dup_cnt     = 0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    bit_in      = '0;
    bit_addr    = '0;
    bit_valid   = 1'b0;
    frame_ready = 1'b0;
    m_gathering = 1'b0;
    m_offered   = 1'b0;
    m_dup       = 1'b0;
    model_clear();

    // Reset state
    tick();
    tick();
    chk("reset_frame_zero", frame_out, '0);
    rst_n = 1'b1;
    tick();

    // Stray inputs while idle have no effect
    frame_ready = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 16'hFFFF;
    tick();
    frame_ready = 1'b0;
    bit_valid   = 1'b0;
    tick();

    // In-order fill, back to back
    pulse_start();
    for (int a = 0; a < CHUNK_NUM; a++) begin
      bit_valid = 1'b1;
      bit_addr  = ADDR_W'(a);
      bit_in    = 16'hA5A5 ^ CHUNK_W'(a);
      if (a == CHUNK_NUM - 1) chk("valid_before_last", CODE_LEN'(frame_valid), '0);
      tick();
    end
    bit_valid = 1'b0;
    chk("valid_after_last", CODE_LEN'(frame_valid), CODE_LEN'(1));
    chk("inorder_top", CODE_LEN'(frame_out[255:240]), CODE_LEN'(16'hA5A5));
    chk("inorder_bot", CODE_LEN'(frame_out[15:0]),    CODE_LEN'(16'hA5AA));
    handshake();

    // Out-of-order fill with consumer backpressure
    shuffle();
    move_front(0, 15);
    move_front(1, 0);
    move_front(2, 7);
    pulse_start();
    write_perm(0, CHUNK_NUM - 1);
    snap = frame_out;
    for (int k = 0; k < 5; k++) begin
      bit_valid = $urandom_range(0, 1) == 1;
      bit_addr  = ADDR_W'($urandom);
      bit_in    = CHUNK_W'($urandom);
      tick();
      chk("hold_stable", frame_out, snap);
      chk("hold_not_ready", CODE_LEN'(bit_ready), '0);
    end
    bit_valid = 1'b0;
    handshake();
    chk("idle_after_hs", CODE_LEN'(busy), '0);

    // Duplicate write to address 3
    dup_cnt = 0;
    pulse_start();
    write_one(3, 16'h1111);
    write_one(3, 16'h2222);
    shuffle();
    move_front(0, 3);
    write_perm(1, CHUNK_NUM - 2);
    chk("dup_not_complete", CODE_LEN'(frame_valid), '0);
    write_perm(CHUNK_NUM - 1, CHUNK_NUM - 1);
    chk("dup_complete", CODE_LEN'(frame_valid), CODE_LEN'(1));
    chk("dup_slot3", CODE_LEN'(frame_out[255-3*16 -: 16]), CODE_LEN'(16'h2222));
    chk("dup_pulses", CODE_LEN'(dup_cnt), CODE_LEN'(1));
    handshake();

    // Abort: restart with a concurrent chunk that must be dropped
    shuffle();
    pulse_start();
    write_perm(0, 7);
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    bit_addr    = ADDR_W'(perm[15]);
    bit_in      = 16'hDEAD;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    chk("abort_frame_zero", frame_out, '0);
    write_perm(0, CHUNK_NUM - 2);
    chk("abort_needs_all", CODE_LEN'(frame_valid), '0);
    write_perm(CHUNK_NUM - 1, CHUNK_NUM - 1);
    chk("abort_complete", CODE_LEN'(frame_valid), CODE_LEN'(1));
    handshake();

    // Reset while a frame is held
    shuffle();
    pulse_start();
    write_perm(0, CHUNK_NUM - 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_hold_valid", CODE_LEN'(frame_valid), '0);
    chk("rst_hold_frame", frame_out, '0);
    chk("rst_hold_ready", CODE_LEN'(bit_ready), '0);
    shuffle();
    pulse_start();
    write_perm(0, CHUNK_NUM - 1);
    handshake();

    // frame_start during HOLD is ignored
    shuffle();
    pulse_start();
    write_perm(0, CHUNK_NUM - 1);
    snap = frame_out;
    pulse_start();
    chk("hold_start_frame", frame_out, snap);
    handshake();
    chk("hold_start_idle", CODE_LEN'(bit_ready), '0);
    chk("hold_start_busy", CODE_LEN'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
